// File: rtl/ac97_record_rx_if.sv
// Record-path bundle between the AC97 SData_In deframer and its neighbours.
// slave  : the deframer (takes serial bits, drives record samples/status).
// master : the surrounding logic (drives serial bits, consumes samples).
// Optional feature macro: AC97_RX_STATS_EN adds the drop_count signal.
interface ac97_record_rx_if #(
    parameter int SAMPLE_WIDTH = 16
);
    logic                    bit_tick;
    logic                    sync;
    logic                    sdata_in;
    logic [SAMPLE_WIDTH-1:0] record_left;
    logic [SAMPLE_WIDTH-1:0] record_right;
    logic                    record_valid;
    logic                    codec_ready;
    logic                    frame_error;
`ifdef AC97_RX_STATS_EN
    logic [7:0]              drop_count;

    modport slave (
        input  bit_tick, sync, sdata_in,
        output record_left, record_right, record_valid,
               codec_ready, frame_error, drop_count
    );
    modport master (
        output bit_tick, sync, sdata_in,
        input  record_left, record_right, record_valid,
               codec_ready, frame_error, drop_count
    );
`else
    modport slave (
        input  bit_tick, sync, sdata_in,
        output record_left, record_right, record_valid,
               codec_ready, frame_error
    );
    modport master (
        output bit_tick, sync, sdata_in,
        input  record_left, record_right, record_valid,
               codec_ready, frame_error
    );
`endif
endinterface

// File: rtl/ac97_record_rx.sv
// AC97 record-path deframer: tracks the 256-bit frame on SData_In, keeps the
// tag validity bits and the first SAMPLE_WIDTH bits of slots 3 and 4, and
// presents one stereo pair per valid frame with a one-cycle strobe.
// Optional feature macro: AC97_RX_STATS_EN adds a saturating drop counter.
//
// state | meaning
// IDLE  | waiting for a sync rise (sync low seen, then high)
// TAG   | collecting tag bits b=1..15; sync must stay high
// DATA  | b=16..255; slots 3/4 shifted in, commit decided at b=95
module ac97_record_rx #(
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    ac97_record_rx_if.slave   rx
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TAG  = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [7:0] LAST_TAG_BIT = 8'd15;
    localparam logic [7:0] TAG12_BIT    = 8'd3;
    localparam logic [7:0] TAG11_BIT    = 8'd4;
    localparam logic [7:0] LEFT_START   = 8'd56;
    localparam logic [7:0] LEFT_END     = 8'(56 + SAMPLE_WIDTH - 1);
    localparam logic [7:0] RIGHT_START  = 8'd76;
    localparam logic [7:0] RIGHT_END    = 8'(76 + SAMPLE_WIDTH - 1);
    localparam logic [7:0] COMMIT_BIT   = 8'd95;
    localparam logic [7:0] LAST_BIT     = 8'd255;

    state_t                  state_q, state_d;
    logic [7:0]              bit_q, bit_d;
    logic                    sync_prev_q;
    logic                    tag15_q, tag15_d;
    logic                    tag12_q, tag12_d;
    logic                    tag11_q, tag11_d;
    logic [SAMPLE_WIDTH-1:0] left_sr_q, left_sr_d;
    logic [SAMPLE_WIDTH-1:0] right_sr_q, right_sr_d;
    logic [SAMPLE_WIDTH-1:0] left_q, left_d;
    logic [SAMPLE_WIDTH-1:0] right_q, right_d;
    logic                    valid_q, valid_d;
    logic                    ready_q, ready_d;
    logic                    err_q, err_d;

    logic                    sync_rise;
    logic                    commit_tick;
    logic                    commit_ok;

    // A rise needs sync low on the previous tick; sync_prev resets high so a
    // frame already in flight at reset is never picked up mid-way.
    assign sync_rise   = rx.bit_tick & rx.sync & ~sync_prev_q;
    assign commit_tick = rx.bit_tick & (state_q == DATA) & ~sync_rise &
                         (bit_q == COMMIT_BIT);
    assign commit_ok   = tag15_q & tag12_q & tag11_q;

    // State and bit index register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            bit_q       <= 8'd0;
            sync_prev_q <= 1'b1;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            if (rx.bit_tick) begin
                sync_prev_q <= rx.sync;
            end
        end
    end

    // Next state and frame bit index; only a tick can move the frame.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        if (rx.bit_tick) begin
            case (state_q)
                IDLE: begin
                    if (sync_rise) begin
                        state_d = TAG;
                        bit_d   = 8'd1;
                    end
                end
                TAG: begin
                    if (!rx.sync) begin
                        state_d = IDLE;
                        bit_d   = 8'd0;
                    end else begin
                        bit_d = bit_q + 8'd1;
                        if (bit_q == LAST_TAG_BIT) begin
                            state_d = DATA;
                        end
                    end
                end
                DATA: begin
                    if (sync_rise) begin
                        state_d = TAG;
                        bit_d   = 8'd1;
                    end else if (bit_q == LAST_BIT) begin
                        state_d = IDLE;
                        bit_d   = 8'd0;
                    end else begin
                        bit_d = bit_q + 8'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    bit_d   = 8'd0;
                end
            endcase
        end
    end

    // Datapath next values: tag capture, slot shifting, commit and strobes.
    always_comb begin
        tag15_d    = tag15_q;
        tag12_d    = tag12_q;
        tag11_d    = tag11_q;
        left_sr_d  = left_sr_q;
        right_sr_d = right_sr_q;
        left_d     = left_q;
        right_d    = right_q;
        ready_d    = ready_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        if (rx.bit_tick) begin
            case (state_q)
                IDLE: begin
                    if (sync_rise) begin
                        tag15_d = rx.sdata_in;
                    end
                end
                TAG: begin
                    if (!rx.sync) begin
                        err_d = 1'b1;
                    end else begin
                        if (bit_q == TAG12_BIT) tag12_d = rx.sdata_in;
                        if (bit_q == TAG11_BIT) tag11_d = rx.sdata_in;
                        if (bit_q == LAST_TAG_BIT) ready_d = tag15_q;
                    end
                end
                DATA: begin
                    if (sync_rise) begin
                        // Rise mid-frame restarts: this tick is tag bit 15.
                        err_d   = 1'b1;
                        tag15_d = rx.sdata_in;
                    end else begin
                        if (bit_q >= LEFT_START && bit_q <= LEFT_END) begin
                            left_sr_d = (left_sr_q << 1) | SAMPLE_WIDTH'(rx.sdata_in);
                        end
                        if (bit_q >= RIGHT_START && bit_q <= RIGHT_END) begin
                            right_sr_d = (right_sr_q << 1) | SAMPLE_WIDTH'(rx.sdata_in);
                        end
                        // With a 20-bit sample the last right bit arrives on
                        // the commit tick itself, hence the _d values.
                        if (bit_q == COMMIT_BIT && commit_ok) begin
                            left_d  = left_sr_d;
                            right_d = right_sr_d;
                            valid_d = 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag15_q    <= 1'b0;
            tag12_q    <= 1'b0;
            tag11_q    <= 1'b0;
            left_sr_q  <= '0;
            right_sr_q <= '0;
            left_q     <= '0;
            right_q    <= '0;
            valid_q    <= 1'b0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            tag15_q    <= tag15_d;
            tag12_q    <= tag12_d;
            tag11_q    <= tag11_d;
            left_sr_q  <= left_sr_d;
            right_sr_q <= right_sr_d;
            left_q     <= left_d;
            right_q    <= right_d;
            valid_q    <= valid_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
        end
    end

    assign rx.record_left  = left_q;
    assign rx.record_right = right_q;
    assign rx.record_valid = valid_q;
    assign rx.codec_ready  = ready_q;
    assign rx.frame_error  = err_q;

`ifdef AC97_RX_STATS_EN
    logic       drop_inc;
    logic [7:0] drop_q;

    // A drop is a ready codec flagging slot 3 or 4 empty, or any sync fault.
    always_comb begin
        drop_inc = err_d | (commit_tick & tag15_q & ~commit_ok);
    end

    // Saturating drop counter, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_q <= 8'd0;
        end else if (drop_inc && drop_q != 8'hFF) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    assign rx.drop_count = drop_q;
`endif

endmodule

// File: tb/tb_ac97_record_rx.sv
// Scoreboard bench for ac97_record_rx: the driver pushes expected sample
// pairs / frame errors (with their expected cycle) as it sends the ticks that
// should cause them; a monitor pops and compares on every output strobe.
module tb_ac97_record_rx;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    ac97_record_rx_if #(.SAMPLE_WIDTH(16)) bus ();

    ac97_record_rx #(.SAMPLE_WIDTH(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .rx      (bus)
    );

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        int          at;
    } exp_t;

    exp_t vq[$];
    int   eq[$];
    exp_t e_mon;
    int   e_at;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    int period = 4;
    bit mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.record_valid === 1'b1) begin
                if (vq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid actual=%0h/%0h at %0d required=none",
                             bus.record_left, bus.record_right, cyc);
                end else begin
                    e_mon = vq.pop_front();
                    chk("record_left", 32'(bus.record_left), 32'(e_mon.l));
                    chk("record_right", 32'(bus.record_right), 32'(e_mon.r));
                    chk("valid_cycle", cyc, e_mon.at);
                end
            end
            if (bus.frame_error === 1'b1) begin
                if (eq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame_error actual=1 at %0d required=0", cyc);
                end else begin
                    e_at = eq.pop_front();
                    chk("error_cycle", cyc, e_at);
                end
            end
        end
    end

    // One bit period: tick on the first clk, idle for the rest.
    task automatic tick(input logic s, input logic d, input bit pv,
                        input logic [15:0] el, input logic [15:0] er, input bit pe);
        exp_t e;
        @(negedge clk);
        bus.bit_tick = 1'b1;
        bus.sync     = s;
        bus.sdata_in = d;
        if (pv) begin
            e.l  = el;
            e.r  = er;
            e.at = cyc + 1;
            vq.push_back(e);
        end
        if (pe) eq.push_back(cyc + 1);
        for (int i = 1; i < period; i++) begin
            @(negedge clk);
            bus.bit_tick = 1'b0;
        end
    endtask

    function automatic logic [255:0] frame_data(input logic [15:0] tag,
                                                input logic [19:0] s3,
                                                input logic [19:0] s4);
        logic [255:0] v;
        v = '0;
        for (int b = 0; b < 256; b++) begin
            if (b < 16)               v[b] = tag[15-b];
            else if (b >= 36 && b < 56) v[b] = 1'b1;
            else if (b >= 56 && b < 76) v[b] = s3[75-b];
            else if (b >= 76 && b < 96) v[b] = s4[95-b];
        end
        return v;
    endfunction

    function automatic logic [255:0] sync_upto(input int n);
        logic [255:0] v;
        v = '0;
        for (int b = 0; b < n; b++) v[b] = 1'b1;
        return v;
    endfunction

    task automatic send(input logic [255:0] sv, input logic [255:0] dv, input int nbits,
                        input int v_at, input logic [15:0] el, input logic [15:0] er,
                        input int e_at);
        for (int b = 0; b < nbits; b++)
            tick(sv[b], dv[b], b == v_at, el, er, b == e_at);
    endtask

    logic [255:0] sv;

    initial begin
        bus.bit_tick = 1'b0;
        bus.sync     = 1'b0;
        bus.sdata_in = 1'b0;
        reset_n      = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_left", 32'(bus.record_left), 0);
        chk("rst_right", 32'(bus.record_right), 0);
        chk("rst_valid", 32'(bus.record_valid), 0);
        chk("rst_ready", 32'(bus.codec_ready), 0);
        chk("rst_error", 32'(bus.frame_error), 0);
`ifdef AC97_RX_STATS_EN
        chk("rst_drop", 32'(bus.drop_count), 0);
`endif
        reset_n = 1'b1;
        mon_en  = 1'b1;
        sv = sync_upto(16);

        repeat (4) tick(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);

        // Valid frame.
        send(sv, frame_data(16'h9800, 20'hABCD5, 20'h12340), 256, 95, 16'hABCD, 16'h1234, -1);
        chk("ready_after_a", 32'(bus.codec_ready), 1);

        // Slot 4 flagged invalid: no strobe, outputs hold.
        send(sv, frame_data(16'h9000, 20'h77777, 20'h88888), 256, -1, 16'h0, 16'h0, -1);
        chk("hold_left", 32'(bus.record_left), 32'h0000ABCD);
        chk("hold_right", 32'(bus.record_right), 32'h00001234);
`ifdef AC97_RX_STATS_EN
        chk("drop_after_b", 32'(bus.drop_count), 1);
`endif

        // Sync dropped at b=7.
        send(sync_upto(7), frame_data(16'h9800, 20'hFFFF0, 20'hEEEE0), 256, -1, 16'h0, 16'h0, 7);
        send(sv, frame_data(16'h9800, 20'h55550, 20'h0ABC0), 256, 95, 16'h5555, 16'h0ABC, -1);
`ifdef AC97_RX_STATS_EN
        chk("drop_after_c", 32'(bus.drop_count), 2);
`endif

        // New sync rise at b=120 restarts the frame.
        send(sv, frame_data(16'h9800, 20'h11110, 20'h22220), 120, 95, 16'h1111, 16'h2222, -1);
        send(sv, frame_data(16'h9800, 20'h33330, 20'h44440), 256, 95, 16'h3333, 16'h4444, 0);
`ifdef AC97_RX_STATS_EN
        chk("drop_after_e", 32'(bus.drop_count), 3);
`endif

        // Codec not ready: codec_ready drops, no sample, not a counted drop.
        send(sv, frame_data(16'h1800, 20'h99990, 20'h88880), 256, -1, 16'h0, 16'h0, -1);
        chk("ready_low", 32'(bus.codec_ready), 0);
        chk("hold_left2", 32'(bus.record_left), 32'h00003333);
`ifdef AC97_RX_STATS_EN
        chk("drop_not_ready", 32'(bus.drop_count), 3);
`endif

        // Reset at b=60 with sync high at release; the following frame is
        // already in flight and must be ignored.
        send(sv, frame_data(16'h9800, 20'hCCCC0, 20'hDDDD0), 60, -1, 16'h0, 16'h0, -1);
        @(negedge clk);
        bus.bit_tick = 1'b0;
        bus.sync     = 1'b1;
        reset_n      = 1'b0;
        @(negedge clk);
        chk("mid_rst_left", 32'(bus.record_left), 0);
        chk("mid_rst_right", 32'(bus.record_right), 0);
        chk("mid_rst_ready", 32'(bus.codec_ready), 0);
`ifdef AC97_RX_STATS_EN
        chk("mid_rst_drop", 32'(bus.drop_count), 0);
`endif
        reset_n = 1'b1;
        send(sv, frame_data(16'h9800, 20'h66660, 20'h77770), 256, -1, 16'h0, 16'h0, -1);
        chk("ignored_left", 32'(bus.record_left), 0);
        send(sv, frame_data(16'h9800, 20'hAAAA0, 20'h55550), 256, 95, 16'hAAAA, 16'h5555, -1);
        chk("ready_after_h", 32'(bus.codec_ready), 1);

        // Tick every clock: three back-to-back frames.
        period = 1;
        send(sv, frame_data(16'h9800, 20'h12345, 20'h6789A), 256, 95, 16'h1234, 16'h6789, -1);
        send(sv, frame_data(16'h9800, 20'hFEDCB, 20'hA9876), 256, 95, 16'hFEDC, 16'hA987, -1);
        send(sv, frame_data(16'h9800, 20'h0F0F0, 20'hF0F0F), 256, 95, 16'h0F0F, 16'hF0F0, -1);
        @(negedge clk);
        bus.bit_tick = 1'b0;
        bus.sync     = 1'b0;
        repeat (5) @(negedge clk);

        chk("pending_valid", 32'(vq.size()), 0);
        chk("pending_error", 32'(eq.size()), 0);
`ifdef AC97_RX_STATS_EN
        chk("drop_final", 32'(bus.drop_count), 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ac97_record_rx.md
# ac97_record_rx

Receive-side deframer for the AC97 serial link: it samples `sdata_in` against `sync` and extracts the tag slot and the left/right PCM record slots (slots 3 and 4). It then presents one 16-bit stereo sample pair per valid frame with a single-cycle strobe. It sits between the codec's `SData_In` pin and the record-path logic, and mirrors the playback path: playback samples are accepted per frame, record samples are emitted per frame.

## Interface
Parameters:
- `SAMPLE_WIDTH`, default 16: PCM bits kept per slot, taken MSB-first from the 20-bit slot; legal range 1..20.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `bit_tick`  in  1  one-cycle strobe; `sync` and `sdata_in` are sampled only on cycles where it is 1; may be high on consecutive cycles.
- `sync`  in  1  AC97 frame sync, high for the 16 tag bits.
- `sdata_in`  in  1  AC97 serial data from the codec, MSB first.
- `record_left`  out  SAMPLE_WIDTH  slot-3 sample; holds between updates.
- `record_right`  out  SAMPLE_WIDTH  slot-4 sample; holds between updates.
- `record_valid`  out  1  one-cycle strobe when `record_left`/`record_right` take new values.
- `codec_ready`  out  1  tag bit 15 of the last complete tag slot.
- `frame_error`  out  1  one-cycle strobe on a sync protocol violation.
- `drop_count`  out  8  saturating count of dropped frames; present only with `AC97_RX_STATS_EN`.

## Operation
- Frame bit index b = 0..255, advanced only on `bit_tick`.
- Tag bits are b = 0..15, holding tag[15-b].
- Slot n (1..12) occupies b = 16+20(n-1) .. 35+20(n-1).
- Slot 3 is b = 56..75; `record_left` is the first SAMPLE_WIDTH bits.
- Slot 4 is b = 76..95; `record_right` is the first SAMPLE_WIDTH bits.
- `sync_prev` is updated on every tick and resets to 1, so a frame already in progress at reset is ignored until `sync` is seen low.
- A sync rise is a tick with `sync`=1 and `sync_prev`=0.
- States:
  - IDLE: on a sync rise, capture tag[15], set b=1, go to TAG.
  - TAG: each tick captures the next tag bit.
    - `sync`=0 on a tick in b=1..15: pulse `frame_error`, go to IDLE, leave outputs unchanged.
    - After the b=15 tick: update `codec_ready` to tag[15] and go to DATA.
  - DATA: shift slot bits into the left/right shift registers over their windows; other slots are ignored.
    - After the b=95 tick, commit the samples if tag[15]&tag[12]&tag[11]=1; otherwise the frame is a drop.
    - A sync rise at any b in 16..255 pulses `frame_error` and is treated as tag bit 0 of a new frame (b=1, TAG).
    - An uncommitted sample is discarded.
    - After the b=255 tick, go to IDLE.
- Sync high during DATA without a rise is ignored.
- `bit_tick` low: no state change, except that pending one-cycle strobes still deassert.

## Timing
- Reset values: `record_left`=0, `record_right`=0, `record_valid`=0, `codec_ready`=0, `frame_error`=0, `drop_count`=0, state=IDLE, `sync_prev`=1.
- `record_valid`, `record_left` and `record_right` update on the clock edge after the cycle carrying the b=95 tick (latency 1 clk).
- `record_valid` is high for exactly 1 clk.
- `codec_ready` updates 1 clk after the b=15 tick.
- `frame_error` is high for exactly 1 clk, 1 clk after the offending tick.
- Reset assertion mid-frame clears everything immediately (asynchronous). The block resynchronises only after seeing `sync` low and then a rise.
- Maximum throughput: one sample pair per 256 ticks.

## Configuration
- `AC97_RX_STATS_EN` defined: `drop_count` exists. It increments, saturating at 255, on each frame that reaches the b=95 tick with codec ready but tag[12] or tag[11] clear, and on each `frame_error`. It holds otherwise and clears only on reset.
- `AC97_RX_STATS_EN` undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset then one frame, tag=16'h9800, slot3=20'hABCD5, slot4=20'h12340, `bit_tick` every 4 clk -> `record_left`=16'hABCD, `record_right`=16'h1234, `record_valid` high 1 clk, 1 clk after the b=95 tick, `codec_ready`=1.
- Frame with tag=16'h9000 (slot 4 invalid) -> no `record_valid`, outputs hold previous values, `drop_count` 0->1 (STATS).
- `sync` dropped at b=7 -> `frame_error` 1 clk, no sample. The next clean frame with slot3=20'h55550 gives `record_left`=16'h5555.
- New sync rise at b=120 of a frame -> `frame_error` 1 clk. The new frame decodes normally and its samples appear after its own b=95 tick.
- `reset_n` pulsed low at b=60 while `sync` is still high at release -> outputs all 0, no decode until `sync` goes low and then rises.
- `bit_tick` held high every clk for 3 back-to-back valid frames -> exactly 3 `record_valid` pulses, 256 clk apart.
